en_round_iter: RTL and testbench

- Iterative AES-128 encryption engine: initial AddRoundKey, then rounds 1..10 with on-the-fly key expansion; round 10 omits MixColumns.
- Generalises the single-round last-round datapath into a parametrised, registered core; UNROLL rounds execute per clock.
- Valid/ready handshake on input and output; sits between the block-level input buffer and the ciphertext output stage.

---
 rtl/en_aes_pkg.sv | 66 ++++++
 rtl/en_round_unit.sv | 53 +++++
 rtl/en_round_iter.sv | 91 +++++++++
 tb/tb_en_round_iter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/en_aes_pkg.sv
// Shared AES-128 constants, types and byte-level helpers for the iterative
// encryption engine and its round unit.
package en_aes_pkg;

    localparam int NR = 10;

    typedef logic [127:0] block_t;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rc);
        case (rc)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic bit legal_unroll(input int u);
        return (u == 1) || (u == 2) || (u == 5) || (u == 10);
    endfunction

endpackage

// File: rtl/en_round_unit.sv
// One combinational AES-128 encryption round together with the matching
// key-schedule step; the final round skips MixColumns.
module en_round_unit
    import en_aes_pkg::*;
(
    input  logic [3:0]   rnd,
    input  logic [127:0] state,
    input  logic [127:0] key,
    output logic [127:0] next_state,
    output logic [127:0] next_key
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] nw0, nw1, nw2, nw3;
    logic [31:0] temp;
    logic [7:0]  sb [16];
    logic [7:0]  sr [16];
    logic [7:0]  mc [16];

    assign {w0, w1, w2, w3} = key;

    always_comb begin
        temp     = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(rnd), 24'h000000};
        nw0      = w0 ^ temp;
        nw1      = w1 ^ nw0;
        nw2      = w2 ^ nw1;
        nw3      = w3 ^ nw2;
        next_key = {nw0, nw1, nw2, nw3};
    end

    // Bytes are column-major: byte 4*c+r holds row r of column c.
    always_comb begin
        next_state = '0;
        for (int i = 0; i < 16; i++) begin
            sb[i] = sbox(state[127 - 8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c + r] = sb[4*((c + r) % 4) + r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[4*c+0] = xtime(sr[4*c+0]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
        for (int i = 0; i < 16; i++) begin
            next_state[127 - 8*i -: 8] = ((rnd == 4'(NR)) ? sr[i] : mc[i]) ^ next_key[127 - 8*i -: 8];
        end
    end

endmodule

// File: rtl/en_round_iter.sv
// Iterative AES-128 encryption core: UNROLL chained rounds per clock with
// on-the-fly key expansion and valid/ready handshakes on both sides.
module en_round_iter
    import en_aes_pkg::*;
#(
    parameter int UNROLL = 1
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] pt_in,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ct_out,
    output logic         busy
);

    if (!legal_unroll(UNROLL)) begin : g_bad_unroll
        $error("en_round_iter: UNROLL must be 1, 2, 5 or 10");
    end

    logic [1:0]   fsm;
    logic [127:0] state_reg;
    logic [127:0] key_reg;
    logic [3:0]   rnd;
    logic         last_round;
    logic [127:0] chain_state [UNROLL+1];
    logic [127:0] chain_key   [UNROLL+1];

    assign chain_state[0] = state_reg;
    assign chain_key[0]   = key_reg;

    for (genvar i = 0; i < UNROLL; i++) begin : g_round
        en_round_unit u_round (
            .rnd        (rnd + 4'(i)),
            .state      (chain_state[i]),
            .key        (chain_key[i]),
            .next_state (chain_state[i+1]),
            .next_key   (chain_key[i+1])
        );
    end

    assign last_round = (rnd + 4'(UNROLL - 1)) == 4'(NR);
    assign in_ready   = (fsm == IDLE);
    assign busy       = (fsm != IDLE);

    // rnd is cleared on completion so it never steps past the final round.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            state_reg <= '0;
            key_reg   <= '0;
            rnd       <= '0;
            ct_out    <= '0;
            out_valid <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state_reg <= pt_in ^ key_in;
                        key_reg   <= key_in;
                        rnd       <= 4'd1;
                        fsm       <= RUN;
                    end
                end
                RUN: begin
                    state_reg <= chain_state[UNROLL];
                    key_reg   <= chain_key[UNROLL];
                    if (last_round) begin
                        ct_out    <= chain_state[UNROLL];
                        out_valid <= 1'b1;
                        rnd       <= '0;
                        fsm       <= DONE;
                    end else begin
                        rnd <= rnd + 4'(UNROLL);
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        fsm       <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_en_round_iter.sv
// Directed bench for en_round_iter: FIPS-197 vectors on all legal UNROLL
// values, handshake backpressure, back-to-back blocks and mid-run reset.
module tb_en_round_iter;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] pt_in;
    logic [127:0] key_in;
    logic [3:0]   rdy;
    logic [3:0]   vld;
    logic [3:0]   bsy;
    logic [127:0] ct [4];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    en_round_iter #(.UNROLL(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
        .pt_in(pt_in), .key_in(key_in), .out_valid(vld[0]), .out_ready(out_ready),
        .ct_out(ct[0]), .busy(bsy[0]));
    en_round_iter #(.UNROLL(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
        .pt_in(pt_in), .key_in(key_in), .out_valid(vld[1]), .out_ready(out_ready),
        .ct_out(ct[1]), .busy(bsy[1]));
    en_round_iter #(.UNROLL(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
        .pt_in(pt_in), .key_in(key_in), .out_valid(vld[2]), .out_ready(out_ready),
        .ct_out(ct[2]), .busy(bsy[2]));
    en_round_iter #(.UNROLL(10)) u_dut10 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[3]),
        .pt_in(pt_in), .key_in(key_in), .out_valid(vld[3]), .out_ready(out_ready),
        .ct_out(ct[3]), .busy(bsy[3]));

    // Latency counts the accept cycle as 1, so the first edge after accept gives 2.
    task automatic run_block(input logic [127:0] pt, input logic [127:0] key, input bit scramble,
                             output int lat, output logic [127:0] got, output bit ok);
        pt_in    = pt;
        key_in   = key;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (scramble) begin
            pt_in  = ~pt;
            key_in = pt ^ key;
        end
        lat = 1;
        ok  = 1'b0;
        got = '0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk); #1;
            lat++;
            if (vld[0]) begin
                ok  = 1'b1;
                got = ct[0];
            end
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pt_in     = '0;
        key_in    = '0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rdy !== 4'b1111) begin failures++; $display("[TB] FAIL reset_in_ready: got %b expected 1111", rdy); end
        checks++; if (vld !== 4'b0000) begin failures++; $display("[TB] FAIL reset_out_valid: got %b expected 0000", vld); end
        checks++; if (bsy !== 4'b0000) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0000", bsy); end
        checks++; if (ct[0] !== 128'h0) begin failures++; $display("[TB] FAIL reset_ct_out: got %h expected 0", ct[0]); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fips_c1();
        int lat;
        logic [127:0] got;
        bit ok;
        run_block(C1_PT, C1_KEY, 1'b0, lat, got, ok);
        checks++; if (!ok || lat != 11) begin failures++; $display("[TB] FAIL c1_latency: got %0d (seen=%0d) expected 11", lat, ok); end
        checks++; if (got !== C1_CT) begin failures++; $display("[TB] FAIL c1_ct: got %h expected %h", got, C1_CT); end
        drain();
    endtask

    task automatic test_fips_b();
        int exp_lat [4] = '{11, 6, 3, 2};
        int lat [4];
        logic [127:0] got [4];
        bit seen [4];
        for (int d = 0; d < 4; d++) begin
            lat[d]  = 0;
            got[d]  = '0;
            seen[d] = 1'b0;
        end
        pt_in    = B_PT;
        key_in   = B_KEY;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int cyc = 2; cyc <= 16; cyc++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 4; d++) begin
                if (vld[d] && !seen[d]) begin
                    seen[d] = 1'b1;
                    lat[d]  = cyc;
                    got[d]  = ct[d];
                end
            end
        end
        for (int d = 0; d < 4; d++) begin
            checks++; if (!seen[d] || lat[d] != exp_lat[d]) begin failures++; $display("[TB] FAIL b_latency[%0d]: got %0d expected %0d", d, lat[d], exp_lat[d]); end
            checks++; if (got[d] !== B_CT) begin failures++; $display("[TB] FAIL b_ct[%0d]: got %h expected %h", d, got[d], B_CT); end
        end
        drain();
        checks++; if (rdy !== 4'b1111) begin failures++; $display("[TB] FAIL b_drain_in_ready: got %b expected 1111", rdy); end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [127:0] got;
        bit ok;
        run_block(C1_PT, C1_KEY, 1'b0, lat, got, ok);
        checks++; if (!ok || got !== C1_CT) begin failures++; $display("[TB] FAIL bp_ct: got %h expected %h", got, C1_CT); end
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                pt_in    = B_PT;
                key_in   = B_KEY;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            checks++;
            if (vld[0] !== 1'b1 || rdy[0] !== 1'b0 || bsy[0] !== 1'b1 || ct[0] !== C1_CT) begin
                failures++;
                $display("[TB] FAIL bp_hold[%0d]: got valid=%b ready=%b busy=%b ct=%h expected 1 0 1 %h", i, vld[0], rdy[0], bsy[0], ct[0], C1_CT);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (vld[0] !== 1'b0) begin failures++; $display("[TB] FAIL bp_release_valid: got %b expected 0", vld[0]); end
        checks++; if (rdy[0] !== 1'b1) begin failures++; $display("[TB] FAIL bp_release_ready: got %b expected 1", rdy[0]); end
        @(posedge clk); #1;
        checks++; if (bsy !== 4'b0000) begin failures++; $display("[TB] FAIL bp_ignored_input: got busy %b expected 0000", bsy); end
    endtask

    task automatic test_back_to_back();
        int e = 0;
        int n = 0;
        int at [2] = '{0, 0};
        logic [127:0] got [2];
        got[0]    = '0;
        got[1]    = '0;
        out_ready = 1'b1;
        pt_in     = C1_PT;
        key_in    = C1_KEY;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        pt_in  = B_PT;
        key_in = B_KEY;
        while (n < 2 && e < 40) begin
            @(posedge clk); #1;
            e++;
            if (vld[0]) begin
                at[n]  = e;
                got[n] = ct[0];
                n++;
                if (n == 2) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        checks++; if (n != 2) begin failures++; $display("[TB] FAIL b2b_count: got %0d outputs expected 2", n); end
        checks++; if (got[0] !== C1_CT) begin failures++; $display("[TB] FAIL b2b_first_ct: got %h expected %h", got[0], C1_CT); end
        checks++; if (got[1] !== B_CT) begin failures++; $display("[TB] FAIL b2b_second_ct: got %h expected %h", got[1], B_CT); end
        checks++; if (at[0] != 10) begin failures++; $display("[TB] FAIL b2b_first_edge: got %0d expected 10", at[0]); end
        checks++; if (at[1] - at[0] != 12) begin failures++; $display("[TB] FAIL b2b_period: got %0d expected 12", at[1] - at[0]); end
        repeat (15) @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int lat;
        logic [127:0] got;
        bit ok;
        bit spurious = 1'b0;
        pt_in    = C1_PT;
        key_in   = C1_KEY;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (bsy[0] !== 1'b1 || rdy[0] !== 1'b0) begin failures++; $display("[TB] FAIL mid_run_busy: got busy=%b ready=%b expected 1 0", bsy[0], rdy[0]); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (vld[0] !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_valid: got %b expected 0", vld[0]); end
        checks++; if (rdy[0] !== 1'b1) begin failures++; $display("[TB] FAIL mid_reset_ready: got %b expected 1", rdy[0]); end
        checks++; if (bsy[0] !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_busy: got %b expected 0", bsy[0]); end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (vld !== 4'b0000) spurious = 1'b1;
        end
        checks++; if (spurious) begin failures++; $display("[TB] FAIL mid_reset_no_output: got out_valid after abort expected none"); end
        run_block(C1_PT, C1_KEY, 1'b0, lat, got, ok);
        checks++; if (!ok || lat != 11) begin failures++; $display("[TB] FAIL post_reset_latency: got %0d expected 11", lat); end
        checks++; if (got !== C1_CT) begin failures++; $display("[TB] FAIL post_reset_ct: got %h expected %h", got, C1_CT); end
        drain();
    endtask

    task automatic test_input_change();
        int lat;
        logic [127:0] got;
        bit ok;
        run_block(B_PT, B_KEY, 1'b1, lat, got, ok);
        checks++; if (!ok || got !== B_CT) begin failures++; $display("[TB] FAIL input_change_ct: got %h expected %h", got, B_CT); end
        drain();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_fips_c1();
        test_fips_b();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_input_change();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
